// File: rtl/maze_ram_arbiter.sv
// maze_ram_arbiter
// Shares the single-port 1-bit maze RAM between the maze generator
// (read/write), the VGA display scanner (read) and the player collision
// checker (read). The generator gets exclusive access while it holds
// gen_lock. Otherwise the two readers are served round-robin, and the
// generator is only served when both readers are idle.
//
// Optional feature: define MAZE_ARB_BOUNDS_CHECK_EN to enable address
// bounds checking. With it, an access at an address >= WIDTH*HEIGHT never
// writes, reads back as WALL (1), and pulses err for the grant cycle.
//
// Handshake (all sampling on the rising clock edge):
//   A requester raises req with a stable addr and keeps both until it sees
//   its gnt. Requests are sampled at edge E_k. The single winner's gnt is
//   high for cycle k+1 only, and ram_address/ram_data/ram_wren carry its
//   access in that same cycle. The RAM latches at E_{k+1}. ram_q is
//   captured at E_{k+2}, and the owner's rvalid/rdata are high for cycle
//   k+3. If req is still high during the gnt cycle, it counts as a new
//   request at E_{k+1}. Writes produce no rvalid.
module maze_ram_arbiter #(
   parameter int WIDTH  = 30,
   parameter int HEIGHT = 40,
   parameter int ADDR_W = 11
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              gen_lock,
   input  logic              gen_req,
   input  logic              gen_we,
   input  logic [ADDR_W-1:0] gen_addr,
   input  logic              gen_wdata,
   output logic              gen_gnt,
   output logic              gen_rvalid,
   output logic              gen_rdata,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_gnt,
   output logic              disp_rvalid,
   output logic              disp_rdata,
   input  logic              plyr_req,
   input  logic [ADDR_W-1:0] plyr_addr,
   output logic              plyr_gnt,
   output logic              plyr_rvalid,
   output logic              plyr_rdata,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_data,
   output logic              ram_wren,
   input  logic              ram_q,
   output logic              err
);

   // The maze must fit in the RAM.
   if (WIDTH * HEIGHT > (2 ** ADDR_W)) begin : g_size_check
      $error("maze_ram_arbiter: WIDTH*HEIGHT exceeds the RAM depth");
   end

   // SHARED: readers round-robin, generator fills idle cycles.
   // DRAIN : no grants for two cycles while reads in flight retire.
   // GEN   : generator only.
   typedef enum logic [1:0] {
      SHARED = 2'd0,
      DRAIN  = 2'd1,
      GEN    = 2'd2
   } state_t;

   // Tag of the read travelling down the data-return pipeline.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_GEN  = 2'd1,
      OWN_DISP = 2'd2,
      OWN_PLYR = 2'd3
   } owner_t;

   state_t            state, state_nx;
   logic [1:0]        drain_cnt, drain_cnt_nx;
   logic              ptr_plyr, ptr_plyr_nx;   // 0: display has priority
   logic              win_gen, win_disp, win_plyr;
   logic              any_win, win_we;
   logic [ADDR_W-1:0] win_addr;
   owner_t            rd_owner;
   logic              oob;

   // Owner-tag pipeline: stage a = grant cycle, stage b = RAM output cycle.
   owner_t            tag_a, tag_b;
   logic              oob_a, oob_b;

   // FSM state, drain counter and round-robin pointer registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= SHARED;
         drain_cnt <= 2'd0;
         ptr_plyr  <= 1'b0;
      end else begin
         state     <= state_nx;
         drain_cnt <= drain_cnt_nx;
         ptr_plyr  <= ptr_plyr_nx;
      end
   end

   // Next state and grant selection from the requests sampled this edge.
   always_comb begin
      state_nx     = state;
      drain_cnt_nx = drain_cnt;
      ptr_plyr_nx  = ptr_plyr;
      win_gen      = 1'b0;
      win_disp     = 1'b0;
      win_plyr     = 1'b0;
      case (state)
         SHARED: begin
            if (gen_lock) begin
               // The lock takes effect at once: no grant in this cycle.
               state_nx     = DRAIN;
               drain_cnt_nx = 2'd0;
            end else if (disp_req && (!plyr_req || !ptr_plyr)) begin
               win_disp    = 1'b1;
               ptr_plyr_nx = 1'b1;
            end else if (plyr_req) begin
               win_plyr    = 1'b1;
               ptr_plyr_nx = 1'b0;
            end else if (gen_req) begin
               win_gen = 1'b1;
            end
         end
         DRAIN: begin
            if (!gen_lock) begin
               state_nx     = SHARED;
               drain_cnt_nx = 2'd0;
            end else if (drain_cnt == 2'd1) begin
               state_nx     = GEN;
               drain_cnt_nx = 2'd0;
            end else begin
               drain_cnt_nx = drain_cnt + 2'd1;
            end
         end
         GEN: begin
            if (!gen_lock) begin
               state_nx = SHARED;
            end else if (gen_req) begin
               win_gen = 1'b1;
            end
         end
         default: begin
            state_nx     = SHARED;
            drain_cnt_nx = 2'd0;
         end
      endcase
   end

   // Winner's address, write flag and read-return owner.
   always_comb begin
      any_win  = win_gen | win_disp | win_plyr;
      win_we   = win_gen & gen_we;
      win_addr = gen_addr;
      rd_owner = OWN_NONE;
      if (win_disp) begin
         win_addr = disp_addr;
         rd_owner = OWN_DISP;
      end else if (win_plyr) begin
         win_addr = plyr_addr;
         rd_owner = OWN_PLYR;
      end else if (win_gen && !gen_we) begin
         rd_owner = OWN_GEN;
      end
   end

`ifdef MAZE_ARB_BOUNDS_CHECK_EN
   localparam logic [ADDR_W:0] CELLS = (ADDR_W + 1)'(WIDTH * HEIGHT);

   assign oob = ({1'b0, win_addr} >= CELLS);

   // Bounds error pulse, high for the grant cycle of an out-of-range access.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         err <= 1'b0;
      end else begin
         err <= any_win & oob;
      end
   end
`else
   assign oob = 1'b0;
   assign err = 1'b0;
`endif

   // Grant pulses and the RAM command for the grant cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         gen_gnt     <= 1'b0;
         disp_gnt    <= 1'b0;
         plyr_gnt    <= 1'b0;
         ram_address <= '0;
         ram_data    <= 1'b0;
         ram_wren    <= 1'b0;
      end else begin
         gen_gnt  <= win_gen;
         disp_gnt <= win_disp;
         plyr_gnt <= win_plyr;
         if (any_win) begin
            ram_address <= win_addr;
         end
         ram_data <= win_we & gen_wdata;
         ram_wren <= win_we & ~oob;
      end
   end

   // Owner tags follow each read so the RAM output reaches its requester.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tag_a <= OWN_NONE;
         tag_b <= OWN_NONE;
         oob_a <= 1'b0;
         oob_b <= 1'b0;
      end else begin
         tag_a <= rd_owner;
         oob_a <= (rd_owner != OWN_NONE) & oob;
         tag_b <= tag_a;
         oob_b <= oob_a;
      end
   end

   // Read-data return: one-cycle rvalid with the captured RAM bit
   // (or WALL for an out-of-range read).
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         gen_rvalid  <= 1'b0;
         gen_rdata   <= 1'b0;
         disp_rvalid <= 1'b0;
         disp_rdata  <= 1'b0;
         plyr_rvalid <= 1'b0;
         plyr_rdata  <= 1'b0;
      end else begin
         gen_rvalid  <= (tag_b == OWN_GEN);
         gen_rdata   <= (tag_b == OWN_GEN) & (oob_b | ram_q);
         disp_rvalid <= (tag_b == OWN_DISP);
         disp_rdata  <= (tag_b == OWN_DISP) & (oob_b | ram_q);
         plyr_rvalid <= (tag_b == OWN_PLYR);
         plyr_rdata  <= (tag_b == OWN_PLYR) & (oob_b | ram_q);
      end
   end

endmodule
